// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 pipeline stall/bubble control with run-state tracking and
// saturating hazard-event counters.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic [2:0]       cpu_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);
    localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {FLUSH, RUN, HALT, ERR} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [2:0]        err_q, err_d;
    logic [CNT_W-1:0]  cyc_q, lu_q, mp_q, ret_q;
    logic              lu, ret, mp, exc_m, exc_w, run, flush, stop;

    assign exc_m = m_stat inside {3'd2, 3'd3, 3'd4};
    assign exc_w = W_stat inside {3'd2, 3'd3, 3'd4};
    // RNONE as a load destination never creates a dependency
    assign lu    = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
                   (E_dstM == d_srcA || E_dstM == d_srcB);
    assign ret   = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    assign mp    = E_icode == 4'h7 && !e_Cnd;
    assign run   = state_q == RUN;
    assign flush = state_q == FLUSH;
    assign stop  = state_q == HALT || state_q == ERR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FLUSH;
            fcnt_q  <= FW'(FLUSH_CYCLES - 1);
            err_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        err_d   = err_q;
        if (flush) begin
            fcnt_d  = fcnt_q == '0 ? fcnt_q : fcnt_q - 1'b1;
            state_d = fcnt_q == '0 ? RUN : FLUSH;
        end else if (run && W_stat == 3'd2) begin
            state_d = HALT;
        end else if (run && (W_stat == 3'd3 || W_stat == 3'd4)) begin
            state_d = ERR;
            err_d   = W_stat;
        end
    end

    always_comb begin
        F_stall  = flush | stop | (run & (lu | ret));
        D_stall  = stop | (run & lu);
        W_stall  = stop | (run & exc_w);
        D_bubble = flush | (run & (mp | (ret & !lu)));
        E_bubble = flush | (run & (mp | lu));
        M_bubble = flush | (run & (exc_m | exc_w));
        set_cc   = run & (E_icode == 4'h6) & !exc_m & !exc_w;
        cpu_stat = state_q == HALT ? 3'd2 : state_q == ERR ? err_q : 3'd1;
    end

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            lu_q  <= '0;
            mp_q  <= '0;
            ret_q <= '0;
        end else if (run) begin
            cyc_q <= cyc_q + CNT_W'(~&cyc_q);
            lu_q  <= lu_q + CNT_W'(lu & ~&lu_q);
            mp_q  <= mp_q + CNT_W'(mp & ~&mp_q);
            ret_q <= ret_q + CNT_W'(ret & ~&ret_q);
        end
    end

    assign cyc_cnt = cyc_q;
    assign lu_cnt  = lu_q;
    assign mp_cnt  = mp_q;
    assign ret_cnt = ret_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl stall/bubble, run state and counters.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
    logic e_Cnd;
    logic [2:0] m_stat, W_stat;
    logic F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc;
    logic [2:0] cpu_stat;
    logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;
    logic F4, D4, W4, Db4, Eb4, Mb4, cc4;
    logic [2:0] stat4;
    logic [3:0] cyc4, lu4, mp4, ret4;
    logic [6:0] ov;
    int n_cmp = 0, n_bad = 0;
    int cyc_exp = 0, lu_exp = 0, mp_exp = 0, ret_exp = 0;
    bit run_exp = 0;

    always #5 clk = ~clk;
    assign ov = {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc};

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .cpu_stat(cpu_stat), .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt),
        .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F4), .D_stall(D4),
        .W_stall(W4), .D_bubble(Db4), .E_bubble(Eb4), .M_bubble(Mb4),
        .set_cc(cc4), .cpu_stat(stat4), .cyc_cnt(cyc4), .lu_cnt(lu4),
        .mp_cnt(mp4), .ret_cnt(ret4)
    );

    task automatic cyc();
        @(posedge clk);
        if (run_exp) cyc_exp++;
        #1;
    endtask

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
    endtask

    task automatic test_flush();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (ov !== 7'b1001110) begin n_bad++; $display("FAIL flush_c0 got=%b exp=%b", ov, 7'b1001110); end
        cyc();
        n_cmp++; if (ov !== 7'b1001110) begin n_bad++; $display("FAIL flush_c1 got=%b exp=%b", ov, 7'b1001110); end
        cyc();
        run_exp = 1;
        n_cmp++; if (ov !== 7'b0000000) begin n_bad++; $display("FAIL run_c2 got=%b exp=%b", ov, 7'b0000000); end
        n_cmp++; if (cpu_stat !== 3'd1) begin n_bad++; $display("FAIL run_stat got=%0d exp=1", cpu_stat); end
    endtask

    task automatic test_reset();
        idle();
        #2;
        n_cmp++; if (ov !== 7'b1001110) begin n_bad++; $display("FAIL rst_out got=%b exp=%b", ov, 7'b1001110); end
        n_cmp++; if (cpu_stat !== 3'd1) begin n_bad++; $display("FAIL rst_stat got=%0d exp=1", cpu_stat); end
        n_cmp++; if (cyc_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_cyc got=%0d exp=0", cyc_cnt); end
        test_flush();
    endtask

    task automatic test_idle();
        repeat (10) cyc();
        n_cmp++; if (cyc_cnt !== 32'd10) begin n_bad++; $display("FAIL idle_cyc got=%0d exp=10", cyc_cnt); end
        n_cmp++; if (ov !== 7'b0000000) begin n_bad++; $display("FAIL idle_out got=%b exp=0", ov); end
    endtask

    task automatic test_saturate();
        repeat (10) cyc();
        n_cmp++; if (cyc4 !== 4'd15) begin n_bad++; $display("FAIL sat_cyc4 got=%0d exp=15", cyc4); end
        n_cmp++; if (cyc_cnt !== 32'd20) begin n_bad++; $display("FAIL sat_cyc32 got=%0d exp=20", cyc_cnt); end
    endtask

    task automatic test_load_use();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        n_cmp++; if (ov !== 7'b1100100) begin n_bad++; $display("FAIL lu_out got=%b exp=%b", ov, 7'b1100100); end
        cyc(); lu_exp++;
        n_cmp++; if (lu_cnt !== 32'(lu_exp)) begin n_bad++; $display("FAIL lu_cnt got=%0d exp=%0d", lu_cnt, lu_exp); end
        E_dstM = 4'hF; d_srcA = 4'hF;
        #1;
        n_cmp++; if (ov !== 7'b0000000) begin n_bad++; $display("FAIL lu_rnone got=%b exp=0", ov); end
        cyc();
        n_cmp++; if (lu_cnt !== 32'(lu_exp)) begin n_bad++; $display("FAIL lu_rnone_cnt got=%0d exp=%0d", lu_cnt, lu_exp); end
        E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6; D_icode = 4'h9;
        #1;
        n_cmp++; if (ov !== 7'b1100100) begin n_bad++; $display("FAIL lu_ret got=%b exp=%b", ov, 7'b1100100); end
        cyc(); lu_exp++; ret_exp++;
        n_cmp++; if (lu_cnt !== 32'(lu_exp)) begin n_bad++; $display("FAIL lu_ret_lu got=%0d exp=%0d", lu_cnt, lu_exp); end
        n_cmp++; if (ret_cnt !== 32'(ret_exp)) begin n_bad++; $display("FAIL lu_ret_ret got=%0d exp=%0d", ret_cnt, ret_exp); end
        idle();
        M_icode = 4'h9;
        #1;
        n_cmp++; if (ov !== 7'b1001000) begin n_bad++; $display("FAIL ret_out got=%b exp=%b", ov, 7'b1001000); end
        cyc(); ret_exp++;
        idle();
    endtask

    task automatic test_mispredict();
        E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        n_cmp++; if (ov !== 7'b0001100) begin n_bad++; $display("FAIL mp_out got=%b exp=%b", ov, 7'b0001100); end
        cyc(); mp_exp++;
        n_cmp++; if (mp_cnt !== 32'(mp_exp)) begin n_bad++; $display("FAIL mp_cnt got=%0d exp=%0d", mp_cnt, mp_exp); end
        D_icode = 4'h9;
        #1;
        n_cmp++; if (ov !== 7'b1001100) begin n_bad++; $display("FAIL mp_ret got=%b exp=%b", ov, 7'b1001100); end
        cyc(); mp_exp++; ret_exp++;
        n_cmp++; if (mp_cnt !== 32'(mp_exp)) begin n_bad++; $display("FAIL mp_ret_mp got=%0d exp=%0d", mp_cnt, mp_exp); end
        n_cmp++; if (ret_cnt !== 32'(ret_exp)) begin n_bad++; $display("FAIL mp_ret_ret got=%0d exp=%0d", ret_cnt, ret_exp); end
        idle();
        E_icode = 4'h7;
        #1;
        n_cmp++; if (ov !== 7'b0000000) begin n_bad++; $display("FAIL jxx_taken got=%b exp=0", ov); end
        cyc();
        idle();
    endtask

    task automatic test_error();
        E_icode = 4'h6;
        #1;
        n_cmp++; if (ov !== 7'b0000001) begin n_bad++; $display("FAIL opq_cc got=%b exp=%b", ov, 7'b0000001); end
        m_stat = 3'd3;
        #1;
        n_cmp++; if (ov !== 7'b0000010) begin n_bad++; $display("FAIL opq_adr got=%b exp=%b", ov, 7'b0000010); end
        cyc();
        idle();
        W_stat = 3'd3;
        #1;
        n_cmp++; if (ov !== 7'b0010010) begin n_bad++; $display("FAIL wadr_out got=%b exp=%b", ov, 7'b0010010); end
        n_cmp++; if (cpu_stat !== 3'd1) begin n_bad++; $display("FAIL wadr_stat got=%0d exp=1", cpu_stat); end
        cyc();
        run_exp = 0;
        idle();
        n_cmp++; if (cpu_stat !== 3'd3) begin n_bad++; $display("FAIL err_stat got=%0d exp=3", cpu_stat); end
        n_cmp++; if (ov !== 7'b1110000) begin n_bad++; $display("FAIL err_out got=%b exp=%b", ov, 7'b1110000); end
        E_icode = 4'h7; e_Cnd = 1'b0;
        repeat (3) cyc();
        n_cmp++; if (ov !== 7'b1110000) begin n_bad++; $display("FAIL err_hold got=%b exp=%b", ov, 7'b1110000); end
        n_cmp++; if (cpu_stat !== 3'd3) begin n_bad++; $display("FAIL err_hold_stat got=%0d exp=3", cpu_stat); end
        n_cmp++; if (cyc_cnt !== 32'(cyc_exp)) begin n_bad++; $display("FAIL err_cyc got=%0d exp=%0d", cyc_cnt, cyc_exp); end
        n_cmp++; if (mp_cnt !== 32'(mp_exp)) begin n_bad++; $display("FAIL err_mp got=%0d exp=%0d", mp_cnt, mp_exp); end
        idle();
    endtask

    task automatic test_halt_reset();
        rst = 1'b1;
        cyc_exp = 0; lu_exp = 0; mp_exp = 0; ret_exp = 0; run_exp = 0;
        #1;
        n_cmp++; if (cpu_stat !== 3'd1) begin n_bad++; $display("FAIL rst_err_stat got=%0d exp=1", cpu_stat); end
        n_cmp++; if (ov !== 7'b1001110) begin n_bad++; $display("FAIL rst_err_out got=%b exp=%b", ov, 7'b1001110); end
        test_flush();
        repeat (3) cyc();
        E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
        cyc(); lu_exp++;
        idle();
        W_stat = 3'd2;
        #1;
        n_cmp++; if (ov !== 7'b0010010) begin n_bad++; $display("FAIL whlt_out got=%b exp=%b", ov, 7'b0010010); end
        cyc();
        run_exp = 0;
        idle();
        n_cmp++; if (cpu_stat !== 3'd2) begin n_bad++; $display("FAIL halt_stat got=%0d exp=2", cpu_stat); end
        n_cmp++; if (ov !== 7'b1110000) begin n_bad++; $display("FAIL halt_out got=%b exp=%b", ov, 7'b1110000); end
        E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
        repeat (3) cyc();
        n_cmp++; if (cyc_cnt !== 32'(cyc_exp)) begin n_bad++; $display("FAIL halt_cyc got=%0d exp=%0d", cyc_cnt, cyc_exp); end
        n_cmp++; if (lu_cnt !== 32'(lu_exp)) begin n_bad++; $display("FAIL halt_lu got=%0d exp=%0d", lu_cnt, lu_exp); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (cpu_stat !== 3'd1) begin n_bad++; $display("FAIL rst_halt_stat got=%0d exp=1", cpu_stat); end
        n_cmp++; if (cyc_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_halt_cyc got=%0d exp=0", cyc_cnt); end
        n_cmp++; if (lu_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_halt_lu got=%0d exp=0", lu_cnt); end
        n_cmp++; if (ov !== 7'b1001110) begin n_bad++; $display("FAIL rst_halt_out got=%b exp=%b", ov, 7'b1001110); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_saturate();
        test_load_use();
        test_mispredict();
        test_error();
        test_halt_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
